alu_pipe_br: RTL

Parametrised, two-stage pipelined integer ALU with branch-compare and RV64 word-op modes, plus valid/ready handshakes on both sides. It is the execute-stage successor of the combinational 64-bit ALU. It takes rs1/rs2 plus funct3/funct7 from decode, returns rd or the branch decision, and carries an opaque tag to the writeback/branch unit. Throughput is one operation per cycle, with full backpressure.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_br_core.sv | 111 +++++++++++
 rtl/alu_pipe_br.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings and the S1 payload type for the pipelined execute ALU.
// Operand and tag fields are sized for the widest build; narrower builds zero-extend.
package alu_pkg;

    localparam int XLEN_MAX  = 64;
    localparam int TAG_W_MAX = 16;

    localparam logic [1:0] MODE_ALU  = 2'b00;
    localparam logic [1:0] MODE_ALUW = 2'b01;
    localparam logic [1:0] MODE_BR   = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [XLEN_MAX-1:0]  rs1;
        logic [XLEN_MAX-1:0]  rs2;
        logic [2:0]           funct3;
        logic                 funct7;
        logic [1:0]           mode;
        logic [TAG_W_MAX-1:0] tag;
    } s1_payload_t;

endpackage

// File: rtl/alu_br_core.sv
// Combinational ALU / word-op / branch-compare evaluation of one S1 payload.
// Illegal encodings force rd and taken to zero.
module alu_br_core
    import alu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit W_OPS_EN = 1'b1
) (
    input  s1_payload_t     op_i,
    output logic [XLEN-1:0] rd_o,
    output logic            taken_o,
    output logic            illegal_o
);

    localparam int SHW     = $clog2(XLEN);
    localparam bit W_LEGAL = W_OPS_EN && (XLEN == 64);

    logic [XLEN-1:0] a, b;
    logic [SHW-1:0]  sh;
    logic            lt_s, lt_u, eq;
    logic [XLEN-1:0] sra_r;

    logic [31:0]     a32, b32, w_r32, sraw_r;
    logic [4:0]      sh32;
    logic [63:0]     w_r64;

    logic [XLEN-1:0] alu_r, w_r;
    logic            alu_ill, w_ill, br_ill, br_taken;

    assign a     = op_i.rs1[XLEN-1:0];
    assign b     = op_i.rs2[XLEN-1:0];
    assign sh    = b[SHW-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = a == b;
    assign sra_r = $unsigned($signed(a) >>> sh);

    assign a32    = a[31:0];
    assign b32    = b[31:0];
    assign sh32   = b[4:0];
    assign sraw_r = $unsigned($signed(a32) >>> sh32);

    always_comb begin
        alu_r   = '0;
        alu_ill = op_i.funct7 && !(op_i.funct3 == F3_ADD || op_i.funct3 == F3_SR);
        case (op_i.funct3)
            F3_ADD:  alu_r = op_i.funct7 ? (a - b) : (a + b);
            F3_SLL:  alu_r = a << sh;
            F3_SLT:  alu_r = {{(XLEN-1){1'b0}}, lt_s};
            F3_SLTU: alu_r = {{(XLEN-1){1'b0}}, lt_u};
            F3_XOR:  alu_r = a ^ b;
            F3_SR:   alu_r = op_i.funct7 ? sra_r : (a >> sh);
            F3_OR:   alu_r = a | b;
            default: alu_r = a & b;
        endcase
    end

    always_comb begin
        w_r32 = '0;
        w_ill = !W_LEGAL;
        case (op_i.funct3)
            F3_ADD:  w_r32 = op_i.funct7 ? (a32 - b32) : (a32 + b32);
            F3_SLL: begin
                w_r32 = a32 << sh32;
                if (op_i.funct7) w_ill = 1'b1;
            end
            F3_SR:   w_r32 = op_i.funct7 ? sraw_r : (a32 >> sh32);
            default: w_ill = 1'b1;
        endcase
        // Widen to 64 first so the XLEN=32 build (always illegal here) still elaborates.
        w_r64 = {{32{w_r32[31]}}, w_r32};
        w_r   = w_r64[XLEN-1:0];
    end

    always_comb begin
        br_taken = 1'b0;
        br_ill   = 1'b0;
        case (op_i.funct3)
            F3_BEQ:  br_taken = eq;
            F3_BNE:  br_taken = !eq;
            F3_BLT:  br_taken = lt_s;
            F3_BGE:  br_taken = !lt_s;
            F3_BLTU: br_taken = lt_u;
            F3_BGEU: br_taken = !lt_u;
            default: br_ill   = 1'b1;
        endcase
    end

    always_comb begin
        rd_o      = '0;
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (op_i.mode)
            MODE_ALU: begin
                illegal_o = alu_ill;
                rd_o      = alu_ill ? '0 : alu_r;
            end
            MODE_ALUW: begin
                illegal_o = w_ill;
                rd_o      = w_ill ? '0 : w_r;
            end
            MODE_BR: begin
                illegal_o = br_ill;
                taken_o   = !br_ill && br_taken;
                rd_o      = {{(XLEN-1){1'b0}}, !br_ill && br_taken};
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe_br.sv
// Two-stage execute ALU: S1 holds the accepted operands, S2 the computed result.
// in_ready looks through to out_ready so a full pipe can drain and refill in one cycle.
module alu_pipe_br
    import alu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit W_OPS_EN = 1'b1,
    parameter int TAG_W    = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  in_rs1_i,
    input  logic [XLEN-1:0]  in_rs2_i,
    input  logic [2:0]       in_funct3_i,
    input  logic             in_funct7_i,
    input  logic [1:0]       in_mode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_rd_o,
    output logic             out_taken_o,
    output logic             out_illegal_o,
    output logic [TAG_W-1:0] out_tag_o
);

    s1_payload_t      in_pl, s1_d, s1_q;
    logic             s1_valid_d, s1_valid_q;
    logic             s2_valid_d, s2_valid_q;
    logic [XLEN-1:0]  s2_rd_d, s2_rd_q;
    logic             s2_taken_d, s2_taken_q;
    logic             s2_ill_d, s2_ill_q;
    logic [TAG_W-1:0] s2_tag_d, s2_tag_q;

    logic [XLEN-1:0]  core_rd;
    logic             core_taken, core_ill;
    logic             s2_adv, accept;

    assign s2_adv     = !s2_valid_q || out_ready_i;
    assign in_ready_o = rst_n_i && (!s1_valid_q || s2_adv);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        in_pl        = '0;
        in_pl.rs1    = XLEN_MAX'(in_rs1_i);
        in_pl.rs2    = XLEN_MAX'(in_rs2_i);
        in_pl.funct3 = in_funct3_i;
        in_pl.funct7 = in_funct7_i;
        in_pl.mode   = in_mode_i;
        in_pl.tag    = TAG_W_MAX'(in_tag_i);
    end

    alu_br_core #(
        .XLEN     (XLEN),
        .W_OPS_EN (W_OPS_EN)
    ) u_core (
        .op_i      (s1_q),
        .rd_o      (core_rd),
        .taken_o   (core_taken),
        .illegal_o (core_ill)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_rd_d    = s2_rd_q;
        s2_taken_d = s2_taken_q;
        s2_ill_d   = s2_ill_q;
        s2_tag_d   = s2_tag_q;
        if (!s1_valid_q || s2_adv) begin
            s1_valid_d = accept;
            if (accept) s1_d = in_pl;
        end
        // An empty S2 presents an all-zero payload.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            s2_rd_d    = s1_valid_q ? core_rd : '0;
            s2_taken_d = s1_valid_q && core_taken;
            s2_ill_d   = s1_valid_q && core_ill;
            s2_tag_d   = s1_valid_q ? s1_q.tag[TAG_W-1:0] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_rd_q    <= '0;
            s2_taken_q <= 1'b0;
            s2_ill_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_rd_q    <= s2_rd_d;
            s2_taken_q <= s2_taken_d;
            s2_ill_q   <= s2_ill_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid_o   = s2_valid_q;
    assign out_rd_o      = s2_rd_q;
    assign out_taken_o   = s2_taken_q;
    assign out_illegal_o = s2_ill_q;
    assign out_tag_o     = s2_tag_q;

endmodule
